meissa_pe_feeder: RTL and testbench
===================================

// Module: meissa_pe_feeder
// PURPOSE
//  Operand transmitter for one meissa PE: fetches len (data, weight) pairs from data and weight SRAMs,
//  streams one pair per cycle on datain/weight with pe_valid/pe_last, honours downstream stall.
//  Sits between operand buffers and the PE; the PE multiplies whatever is presented each cycle.
// PARAMETERS
//  DATA_WIDTH  16  operand width, equal to the PE datain/weight width
//  ADDR_WIDTH  10  SRAM address width; addresses wrap modulo 2**ADDR_WIDTH
//  LEN_WIDTH   10  width of len; max burst = 2**LEN_WIDTH-1 pairs
// PORTS
//  clk            in   1           clock, all logic on posedge
//  reset          in   1           asynchronous, active-low reset
//  start          in   1           burst request; sampled only in IDLE
//  data_base      in   ADDR_WIDTH  first data address
//  weight_base    in   ADDR_WIDTH  first weight address
//  len            in   LEN_WIDTH   pairs in burst; 0 = empty burst
//  busy           out  1           high from cycle after accepted start until done
//  done           out  1           1-cycle pulse, burst complete
//  data_rd_en     out  1           data SRAM read strobe
//  data_rd_addr   out  ADDR_WIDTH  data SRAM address
//  data_rd_data   in   DATA_WIDTH  data SRAM read data, valid 1 cycle after data_rd_en
//  weight_rd_en   out  1           weight SRAM read strobe; always equal to data_rd_en
//  weight_rd_addr out  ADDR_WIDTH  weight SRAM address
//  weight_rd_data in   DATA_WIDTH  weight SRAM read data, 1-cycle latency
//  stall          in   1           downstream cannot consume the presented pair
//  datain         out  DATA_WIDTH  operand to PE
//  weight         out  DATA_WIDTH  weight to PE
//  pe_valid       out  1           datain/weight hold a real pair
//  pe_last        out  1           presented pair is the final one of the burst
// BEHAVIOUR
//  Reset: every output 0. FSM to IDLE. Counters, skid entries and in-flight reads are cleared and discarded.
//  Reset mid-burst aborts the burst; no done pulse.
//  FSM IDLE->RUN on start. Ignored if len==0; see below.
//  RUN->DRAIN when the last read is issued. DRAIN->IDLE when the last pair is consumed.
//  start while busy is ignored.
//  Empty burst: start with len==0 gives done=1 the next cycle. No reads. busy stays 0.
//  Both SRAM reads are issued in the same cycle with identical address offset i (0..len-1).
//  Consume: a pair is consumed at a clock edge where pe_valid=1 and stall=0.
//  While stall=1, datain/weight/pe_valid/pe_last hold unchanged.
//  Read issue is credit-gated: issue only if output reg + 2-entry skid + in-flight have a free slot.
//  Read data is never dropped or duplicated. Pair order is strictly ascending i.
//  Throughput: 1 pair/cycle with stall=0 continuously.
//  Latency: start accepted at edge E -> rd_en high in cycle E+1 -> pe_valid high from edge E+3.
//  Stall may assert/deassert any cycle, including the pe_last cycle and the first pe_valid cycle.
//  done: 1-cycle pulse the cycle after the pe_last pair is consumed; busy falls in the same cycle.
//  A new start may be accepted in the done cycle.
//  Addresses: base+i computed modulo 2**ADDR_WIDTH; crossing the top address wraps to 0 silently.
// CONFIGURATION
//  MEISSA_FEEDER_ZERO_IDLE_EN defined:
//    datain and weight are driven 0 whenever pe_valid=0, so the PE product is 0 in bubble cycles.
//  Not defined:
//    datain/weight keep the last presented pair when pe_valid=0 (lower toggle power);
//    consumers must qualify with pe_valid.
// STRUCTURE
//  Shared package meissa_pkg holds the FSM state encoding (IDLE/RUN/DRAIN) and the default
//  DATA_WIDTH/ADDR_WIDTH/LEN_WIDTH constants shared with the PE array.
//  One sub-module: meissa_skid_fifo, a 2-entry {data,weight,last} FIFO with count output.
// TESTING
//  1 len=4, data_base=0x010, weight_base=0x200, stall=0: addresses 0x010..0x013 and 0x200..0x203 read;
//    pe_valid high 4 consecutive cycles from E+3; pe_last on the 4th pair; done one cycle later.
//  2 len=6, stall high for 3 cycles after the 2nd pair: the held pair is unchanged while stalled;
//    all 6 pairs are delivered in order with no loss or duplicate; total reads = 6.
//  3 len=0 start: done the next cycle; busy, data_rd_en and pe_valid never assert.
//  4 data_base=0x3FE, len=4: data addresses 0x3FE, 0x3FF, 0x000, 0x001.
//  5 reset low during pair 3 of len=8: all outputs 0 asynchronously; no done;
//    a new burst with len=2 after reset delivers exactly 2 pairs.
//  6 start held high across the burst and pulsed in the done cycle: the 2nd start is accepted;
//    starts while busy are ignored. Run once with the macro defined (datain=0 in bubbles)
//    and once without (values held).

Source files
------------

// File: rtl/meissa_pkg.sv
// Shared meissa definitions: feeder FSM state encoding and the default
// operand, address and length widths used across the PE array.
package meissa_pkg;

  localparam int MEISSA_DATA_WIDTH = 16;
  localparam int MEISSA_ADDR_WIDTH = 10;
  localparam int MEISSA_LEN_WIDTH  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/meissa_skid_fifo.sv
// Two-entry FIFO holding {last, data, weight} pairs that arrive while the
// PE output register is occupied; push and pop may occur in the same cycle.
module meissa_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;

  // entry storage and write pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
    end else if (push) begin
      mem_r[wr_ptr_r] <= wdata;
      wr_ptr_r        <= ~wr_ptr_r;
    end
  end

  // read pointer and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/meissa_pe_feeder.sv
// Operand feeder for one meissa PE: credit-gated SRAM reads into an output
// register backed by a 2-entry skid FIFO. MEISSA_FEEDER_ZERO_IDLE_EN zeroes datain/weight in bubbles.
module meissa_pe_feeder
  import meissa_pkg::*;
#(
  parameter int DATA_WIDTH = MEISSA_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEISSA_ADDR_WIDTH,
  parameter int LEN_WIDTH  = MEISSA_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] data_base,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  data_rd_en,
  output logic [ADDR_WIDTH-1:0] data_rd_addr,
  input  logic [DATA_WIDTH-1:0] data_rd_data,
  output logic                  weight_rd_en,
  output logic [ADDR_WIDTH-1:0] weight_rd_addr,
  input  logic [DATA_WIDTH-1:0] weight_rd_data,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] weight,
  output logic                  pe_valid,
  output logic                  pe_last
);

  localparam int PAIR_WIDTH = 2 * DATA_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  feeder_state_e           state_r, state_next_s;
  logic [LEN_WIDTH-1:0]    len_r, issue_cnt_r;
  logic [ADDR_WIDTH-1:0]   data_base_r, weight_base_r, data_addr_r, weight_addr_r;
  logic                    rd_en_r, rd_last_r, rd_valid_r, rd_valid_last_r;
  logic [DATA_WIDTH-1:0]   datain_r, weight_r;
  logic                    pe_valid_r, pe_last_r, busy_r, done_r;
  logic                    issue_s, issue_last_s, cons_s, load_s, done_s;
  logic                    from_fifo_s, from_rd_s, fifo_push_s;
  logic [2:0]              occupancy_s;
  logic [1:0]              fifo_count_s;
  logic [PAIR_WIDTH-1:0]   fifo_rdata_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (start && (|len))             state_next_s = ST_RUN;   else state_next_s = ST_IDLE;
      ST_RUN:   if (issue_s && issue_last_s)     state_next_s = ST_DRAIN; else state_next_s = ST_RUN;
      ST_DRAIN: if (cons_s && pe_last_r)         state_next_s = ST_IDLE;  else state_next_s = ST_DRAIN;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: credit-gated issue, done request and output-register refill steering
  always_comb begin
    cons_s       = pe_valid_r & ~stall;
    occupancy_s  = {2'b00, pe_valid_r} + {1'b0, fifo_count_s} + {2'b00, rd_en_r} + {2'b00, rd_valid_r};
    issue_last_s = (issue_cnt_r == (len_r - LEN_ONE));
    // a slot freed by this edge's consume is reusable, which keeps 1 pair/cycle
    if (state_r == ST_RUN) issue_s = ((occupancy_s - {2'b00, cons_s}) < 3'd3);
    else                   issue_s = 1'b0;
    case (state_r)
      ST_IDLE:  done_s = start & ~(|len);
      ST_DRAIN: done_s = cons_s & pe_last_r;
      default:  done_s = 1'b0;
    endcase
    load_s      = ~pe_valid_r | cons_s;
    from_fifo_s = load_s & (fifo_count_s != 2'd0);
    from_rd_s   = load_s & (fifo_count_s == 2'd0) & rd_valid_r;
    fifo_push_s = rd_valid_r & ~from_rd_s;
  end

  // burst capture, read issue and read-return tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_r           <= {LEN_WIDTH{1'b0}};
      issue_cnt_r     <= {LEN_WIDTH{1'b0}};
      data_base_r     <= {ADDR_WIDTH{1'b0}};
      weight_base_r   <= {ADDR_WIDTH{1'b0}};
      data_addr_r     <= {ADDR_WIDTH{1'b0}};
      weight_addr_r   <= {ADDR_WIDTH{1'b0}};
      rd_en_r         <= 1'b0;
      rd_last_r       <= 1'b0;
      rd_valid_r      <= 1'b0;
      rd_valid_last_r <= 1'b0;
    end else begin
      rd_en_r         <= issue_s;
      rd_last_r       <= issue_s & issue_last_s;
      rd_valid_r      <= rd_en_r;
      rd_valid_last_r <= rd_last_r;
      if (issue_s) begin
        data_addr_r   <= data_base_r + ADDR_WIDTH'(issue_cnt_r);
        weight_addr_r <= weight_base_r + ADDR_WIDTH'(issue_cnt_r);
        issue_cnt_r   <= issue_cnt_r + LEN_ONE;
      end else if ((state_r == ST_IDLE) && start) begin
        len_r         <= len;
        data_base_r   <= data_base;
        weight_base_r <= weight_base;
        issue_cnt_r   <= {LEN_WIDTH{1'b0}};
      end
    end
  end

  // output register: refilled from the skid FIFO first, then from the SRAM return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_valid_r <= 1'b0;
      pe_last_r  <= 1'b0;
      datain_r   <= {DATA_WIDTH{1'b0}};
      weight_r   <= {DATA_WIDTH{1'b0}};
    end else if (from_fifo_s) begin
      pe_valid_r <= 1'b1;
      {pe_last_r, datain_r, weight_r} <= fifo_rdata_s;
    end else if (from_rd_s) begin
      pe_valid_r <= 1'b1;
      pe_last_r  <= rd_valid_last_r;
      datain_r   <= data_rd_data;
      weight_r   <= weight_rd_data;
    end else if (load_s) begin
      pe_valid_r <= 1'b0;
      pe_last_r  <= 1'b0;
`ifdef MEISSA_FEEDER_ZERO_IDLE_EN
      datain_r   <= {DATA_WIDTH{1'b0}};
      weight_r   <= {DATA_WIDTH{1'b0}};
`endif
    end
  end

  // busy/done status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= done_s;
    end
  end

  meissa_skid_fifo #(.WIDTH(PAIR_WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .wdata ({rd_valid_last_r, data_rd_data, weight_rd_data}),
    .pop   (from_fifo_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s)
  );

  assign busy           = busy_r;
  assign done           = done_r;
  assign data_rd_en     = rd_en_r;
  assign weight_rd_en   = rd_en_r;
  assign data_rd_addr   = data_addr_r;
  assign weight_rd_addr = weight_addr_r;
  assign datain         = datain_r;
  assign weight         = weight_r;
  assign pe_valid       = pe_valid_r;
  assign pe_last        = pe_last_r;

endmodule

// File: tb/tb_meissa_pe_feeder.sv
// Directed bench for meissa_pe_feeder: SRAM models, scoreboard of expected
// addresses and pairs, and a negedge monitor that checks every cycle.
module tb_meissa_pe_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  data_base = 10'd0;
  logic [9:0]  weight_base = 10'd0;
  logic [9:0]  len = 10'd0;
  logic        busy, done, data_rd_en, weight_rd_en, pe_valid, pe_last;
  logic [9:0]  data_rd_addr, weight_rd_addr;
  logic [15:0] data_rd_data = 16'd0;
  logic [15:0] weight_rd_data = 16'd0;
  logic        stall = 1'b0;
  logic [15:0] datain, weight;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] w;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  daddr_q[$];
  logic [9:0]  waddr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          valid_cnt = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, nxt_busy, nxt_done;
  logic        hold_v = 1'b0, hold_last = 1'b0;
  logic [15:0] hold_d = 16'd0, hold_w = 16'd0, last_d = 16'd0, last_w = 16'd0;
  logic [9:0]  ea, eb, off;
  exp_t        e;
  int          base_rd, base_valid, n;
  logic        seen;

  meissa_pe_feeder dut (
    .clk(clk), .reset(reset), .start(start), .data_base(data_base),
    .weight_base(weight_base), .len(len), .busy(busy), .done(done),
    .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
    .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr),
    .weight_rd_data(weight_rd_data), .stall(stall), .datain(datain),
    .weight(weight), .pe_valid(pe_valid), .pe_last(pe_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dval(input logic [9:0] a);
    return {6'h34, a};
  endfunction

  function automatic logic [15:0] wval(input logic [9:0] a);
    return 16'h0100 + ({6'd0, a} * 16'd7);
  endfunction

  always @(posedge clk) begin
    if (data_rd_en)   data_rd_data   <= dval(data_rd_addr);
    if (weight_rd_en) weight_rd_data <= wval(weight_rd_addr);
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete(); daddr_q.delete(); waddr_q.delete();
      m_busy = 1'b0; m_done = 1'b0; hold_v = 1'b0;
      last_d = 16'd0; last_w = 16'd0;
    end else begin
      checks++; assert (busy === m_busy) else begin errors++; $error("FAIL busy observed=%0b expected=%0b", busy, m_busy); end
      checks++; assert (done === m_done) else begin errors++; $error("FAIL done observed=%0b expected=%0b", done, m_done); end
      checks++; assert (weight_rd_en === data_rd_en) else begin errors++; $error("FAIL rd_en_pair observed=%0b expected=%0b", weight_rd_en, data_rd_en); end
      if (data_rd_en) begin
        rd_cnt++;
        checks++; assert (daddr_q.size() != 0) else begin errors++; $error("FAIL rd_unexpected observed=%0d expected=nonzero", daddr_q.size()); end
        if (daddr_q.size() != 0) begin
          ea = daddr_q.pop_front(); eb = waddr_q.pop_front();
          checks++; assert (data_rd_addr === ea) else begin errors++; $error("FAIL data_addr observed=%h expected=%h", data_rd_addr, ea); end
          checks++; assert (weight_rd_addr === eb) else begin errors++; $error("FAIL weight_addr observed=%h expected=%h", weight_rd_addr, eb); end
        end
      end
      if (hold_v) begin
        checks++; assert ({pe_valid, pe_last, datain, weight} === {1'b1, hold_last, hold_d, hold_w})
          else begin errors++; $error("FAIL stall_hold observed=%b/%b/%h/%h expected=1/%b/%h/%h", pe_valid, pe_last, datain, weight, hold_last, hold_d, hold_w); end
      end
      if (!pe_valid) begin
`ifdef MEISSA_FEEDER_ZERO_IDLE_EN
        checks++; assert ({datain, weight} === 32'd0) else begin errors++; $error("FAIL bubble_zero observed=%h/%h expected=0/0", datain, weight); end
`else
        checks++; assert ({datain, weight} === {last_d, last_w}) else begin errors++; $error("FAIL bubble_hold observed=%h/%h expected=%h/%h", datain, weight, last_d, last_w); end
`endif
      end else begin
        valid_cnt++; last_d = datain; last_w = weight;
      end
      nxt_done = 1'b0; nxt_busy = m_busy;
      if (!m_busy && start) begin
        if (len == 10'd0) nxt_done = 1'b1;
        else begin
          nxt_busy = 1'b1;
          for (int i = 0; i < int'(len); i++) begin
            off = 10'(i);
            daddr_q.push_back(data_base + off);
            waddr_q.push_back(weight_base + off);
            exp_q.push_back('{d: dval(data_base + off), w: wval(weight_base + off), last: (i == int'(len) - 1)});
          end
        end
      end
      hold_v = pe_valid & stall; hold_last = pe_last; hold_d = datain; hold_w = weight;
      if (pe_valid && !stall) begin
        checks++; assert (exp_q.size() != 0) else begin errors++; $error("FAIL pair_unexpected observed=%0d expected=nonzero", exp_q.size()); end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++; assert ({datain, weight, pe_last} === {e.d, e.w, e.last})
            else begin errors++; $error("FAIL pair observed=%h/%h/%b expected=%h/%h/%b", datain, weight, pe_last, e.d, e.w, e.last); end
          if (e.last) begin nxt_done = 1'b1; nxt_busy = 1'b0; end
        end
      end
      m_busy = nxt_busy; m_done = nxt_done;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    n = 0;
    while ((busy || done || m_busy || exp_q.size() != 0) && n < budget) begin step(); n++; end
    checks++; assert (n < budget) else begin errors++; $error("FAIL idle_timeout observed=%0d expected<%0d", n, budget); end
    step(); step();
  endtask

  task automatic wait_valid(input int budget);
    n = 0;
    while (!pe_valid && n < budget) begin step(); n++; end
    checks++; assert (n < budget) else begin errors++; $error("FAIL valid_timeout observed=%0d expected<%0d", n, budget); end
  endtask

  task automatic burst(input logic [9:0] db, input logic [9:0] wb, input logic [9:0] l);
    step(); start = 1'b1; data_base = db; weight_base = wb; len = l;
    step(); start = 1'b0;
  endtask

  initial begin
    // reset state
    step(); step();
    checks++; assert ({busy, done, data_rd_en, weight_rd_en, data_rd_addr, weight_rd_addr, datain, weight, pe_valid, pe_last} === 58'd0)
      else begin errors++; $error("FAIL reset_state observed=nonzero expected=0"); end
    reset = 1'b1;
    step();

    // 1: len=4 latency and back-to-back delivery
    base_valid = valid_cnt;
    burst(10'h010, 10'h200, 10'd4);
    checks++; assert ({busy, data_rd_en} === 2'b10) else begin errors++; $error("FAIL t1_E observed=%b expected=10", {busy, data_rd_en}); end
    step();
    checks++; assert ({data_rd_en, data_rd_addr} === {1'b1, 10'h010}) else begin errors++; $error("FAIL t1_E1 observed=%b/%h expected=1/010", data_rd_en, data_rd_addr); end
    step();
    checks++; assert (pe_valid === 1'b0) else begin errors++; $error("FAIL t1_E2 observed=%b expected=0", pe_valid); end
    step();
    checks++; assert (pe_valid === 1'b1) else begin errors++; $error("FAIL t1_E3 observed=%b expected=1", pe_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; assert ({pe_valid, pe_last} === {1'b1, (i == 2)}) else begin errors++; $error("FAIL t1_run observed=%b%b expected=1%b", pe_valid, pe_last, (i == 2)); end
    end
    step();
    checks++; assert ({pe_valid, done, busy} === 3'b010) else begin errors++; $error("FAIL t1_done observed=%b expected=010", {pe_valid, done, busy}); end
    wait_idle(50);
    checks++; assert (valid_cnt - base_valid === 4) else begin errors++; $error("FAIL t1_count observed=%0d expected=4", valid_cnt - base_valid); end

    // 2: len=6 with a 3-cycle stall after the 2nd pair
    base_rd = rd_cnt;
    burst(10'h100, 10'h080, 10'd6);
    wait_valid(20);
    step(); step();
    stall = 1'b1;
    step(); step(); step();
    stall = 1'b0;
    wait_idle(60);
    checks++; assert (rd_cnt - base_rd === 6) else begin errors++; $error("FAIL t2_reads observed=%0d expected=6", rd_cnt - base_rd); end

    // 3: empty burst
    base_rd = rd_cnt; base_valid = valid_cnt;
    burst(10'h020, 10'h020, 10'd0);
    checks++; assert ({done, busy} === 2'b10) else begin errors++; $error("FAIL t3_done observed=%b expected=10", {done, busy}); end
    wait_idle(10);
    checks++; assert ((rd_cnt - base_rd) + (valid_cnt - base_valid) === 0) else begin errors++; $error("FAIL t3_quiet observed=%0d expected=0", (rd_cnt - base_rd) + (valid_cnt - base_valid)); end

    // 4: address wrap
    burst(10'h3FE, 10'h3FD, 10'd4);
    wait_idle(50);

    // random stall, including first-valid and last cycles
    burst(10'h155, 10'h2AA, 10'd10);
    for (int i = 0; i < 50; i++) begin
      stall = 1'($urandom_range(0, 1));
      step();
    end
    stall = 1'b0;
    wait_idle(60);

    // 5: asynchronous reset during pair 3, then a clean len=2 burst
    burst(10'h030, 10'h330, 10'd8);
    wait_valid(20);
    step(); step();
    #2 reset = 1'b0;
    #1;
    checks++; assert ({busy, done, data_rd_en, weight_rd_en, data_rd_addr, weight_rd_addr, datain, weight, pe_valid, pe_last} === 58'd0)
      else begin errors++; $error("FAIL t5_async_reset observed=nonzero expected=0"); end
    step(); step();
    reset = 1'b1;
    step(); step();
    base_valid = valid_cnt;
    burst(10'h060, 10'h070, 10'd2);
    wait_idle(40);
    checks++; assert (valid_cnt - base_valid === 2) else begin errors++; $error("FAIL t5_after observed=%0d expected=2", valid_cnt - base_valid); end

    // 6: start held through the burst, re-accepted in the done cycle
    step(); start = 1'b1; len = 10'd3; data_base = 10'h040; weight_base = 10'h140;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin step(); if (done) seen = 1'b1; end
    checks++; assert (seen === 1'b1) else begin errors++; $error("FAIL t6_done_timeout observed=%b expected=1", seen); end
    data_base = 10'h050; weight_base = 10'h150; len = 10'd2;
    step(); start = 1'b0;
    checks++; assert (busy === 1'b1) else begin errors++; $error("FAIL t6_restart observed=%b expected=1", busy); end
    wait_idle(40);

    checks++; assert (exp_q.size() + daddr_q.size() === 0) else begin errors++; $error("FAIL leftover observed=%0d expected=0", exp_q.size() + daddr_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
